ras_ctrl: RTL and testbench

- Return-address-stack controller; sits directly upstream of the stack block (PUSH=1, POP=1 configuration) and drives its push_/wd/pop_/flush_ inputs.
- Converts front-end call/return events into stack operations.
- Produces a registered return-target prediction from the stack top.
- Tracks calls lost to stack overflow so returns past the live stack depth are flagged unpredictable instead of mispredicted.

---
 rtl/ras_ctrl.sv | 105 ++++++++++
 tb/tb_ras_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: turns call/return events into push/pop strobes for
// the stack, registers a return prediction and tracks calls lost to stack overflow.
module ras_ctrl #(
    parameter int ADDR       = 32,
    parameter int INST_BYTES = 4,
    parameter int OVF_MAX    = 15
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            flush_,
    input  logic            call_,
    input  logic            ret_,
    input  logic [ADDR-1:0] call_pc,
    output logic            st_push_,
    output logic [ADDR-1:0] st_wd,
    output logic            st_pop_,
    output logic            st_flush_,
    input  logic [ADDR-1:0] st_rd,
    input  logic            st_v,
    input  logic            st_busy,
    output logic [ADDR-1:0] pred_addr,
    output logic            pred_v,
    output logic            ovf,
    output logic            lost,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(OVF_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVF_MAX);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        OVF = 2'd1,
        SAT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   ovf_cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            call;
    logic            ret;
    logic            flush;
    logic            pop_req;
    logic            push_req;
    logic            lost_set;

    // Strobes are forced idle while reset_ is low so nothing reaches the stack during reset.
    assign call  = !call_  && reset_;
    assign ret   = !ret_   && reset_;
    assign flush = !flush_ && reset_;

    assign st_wd = call_pc + ADDR'(INST_BYTES);

    // A push alongside a pop replaces the top, so the full flag does not block it.
    assign pop_req  = ret && !flush && (state == RUN) && st_v;
    assign push_req = call && !flush && (state == RUN) && (pop_req || !st_busy);

    assign st_push_  = !push_req;
    assign st_pop_   = !pop_req;
    assign st_flush_ = !flush;

    assign dbg_state = state;

    always_comb begin
        cnt_nxt  = ovf_cnt;
        lost_set = 1'b0;
        if (flush) begin
            cnt_nxt = '0;
        end else if (call && !ret) begin
            if (!push_req) begin
                if (ovf_cnt == CNT_MAX) lost_set = 1'b1;
                else                    cnt_nxt  = ovf_cnt + 1'b1;
            end
        end else if (ret && !call) begin
            if (state != RUN) cnt_nxt = ovf_cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = OVF;
        if (cnt_nxt == '0)          state_nxt = RUN;
        else if (cnt_nxt == CNT_MAX) state_nxt = SAT;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= RUN;
            ovf_cnt   <= '0;
            ovf       <= 1'b0;
            lost      <= 1'b0;
            pred_v    <= 1'b0;
            pred_addr <= '0;
        end else begin
            state   <= state_nxt;
            ovf_cnt <= cnt_nxt;
            ovf     <= (state_nxt != RUN);
            pred_v  <= pop_req;
            if (pop_req) pred_addr <= st_rd;
            if (flush)         lost <= 1'b0;
            else if (lost_set) lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with a small 4-deep behavioural stack attached.
module tb_ras_ctrl;

    localparam int ADDR = 32;
    localparam int OVF_MAX = 15;
    localparam int DEPTH = 4;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_OVF = 2'd1;
    localparam logic [1:0] S_SAT = 2'd2;

    logic            clk;
    logic            reset_;
    logic            flush_;
    logic            call_;
    logic            ret_;
    logic [ADDR-1:0] call_pc;
    logic            st_push_;
    logic [ADDR-1:0] st_wd;
    logic            st_pop_;
    logic            st_flush_;
    logic [ADDR-1:0] st_rd;
    logic            st_v;
    logic            st_busy;
    logic [ADDR-1:0] pred_addr;
    logic            pred_v;
    logic            ovf;
    logic            lost;
    logic [1:0]      dbg_state;

    int n_cmp;
    int n_bad;

    ras_ctrl #(.ADDR(ADDR), .INST_BYTES(4), .OVF_MAX(OVF_MAX)) dut (
        .clk       (clk),
        .reset_    (reset_),
        .flush_    (flush_),
        .call_     (call_),
        .ret_      (ret_),
        .call_pc   (call_pc),
        .st_push_  (st_push_),
        .st_wd     (st_wd),
        .st_pop_   (st_pop_),
        .st_flush_ (st_flush_),
        .st_rd     (st_rd),
        .st_v      (st_v),
        .st_busy   (st_busy),
        .pred_addr (pred_addr),
        .pred_v    (pred_v),
        .ovf       (ovf),
        .lost      (lost),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural stack model
    logic [ADDR-1:0] stk [DEPTH];
    int sp;

    always_comb begin
        st_v    = (sp != 0);
        st_busy = (sp == DEPTH);
        st_rd   = '0;
        if (sp > 0) st_rd = stk[sp-1];
    end

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            sp <= 0;
        end else if (!st_flush_) begin
            sp <= 0;
        end else if (!st_push_ && !st_pop_) begin
            stk[sp-1] <= st_wd;
        end else if (!st_push_) begin
            stk[sp] <= st_wd;
            sp <= sp + 1;
        end else if (!st_pop_) begin
            sp <= sp - 1;
        end
    end

    // driver tasks
    task automatic chk(input string tag, input logic [ADDR-1:0] obs, input logic [ADDR-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c_, input logic r_, input logic f_, input logic [ADDR-1:0] pc);
        call_   = c_;
        ret_    = r_;
        flush_  = f_;
        call_pc = pc;
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 1'b1, '0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_ = 1'b0;
        idle();
        cycle();
        cycle();

        // reset state
        chk("rst_pred_addr", pred_addr, 32'h0);
        chk("rst_pred_v", {31'b0, pred_v}, 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'h0);
        chk("rst_lost", {31'b0, lost}, 32'h0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, S_RUN});
        drive(1'b0, 1'b1, 1'b1, 32'h1000);
        chk("rst_push_gated", {31'b0, st_push_}, 32'h1);
        idle();
        reset_ = 1'b1;
        cycle();

        // 1: call then return
        drive(1'b0, 1'b1, 1'b1, 32'h1000);
        chk("t1_push", {31'b0, st_push_}, 32'h0);
        chk("t1_wd", st_wd, 32'h1004);
        chk("t1_no_pop", {31'b0, st_pop_}, 32'h1);
        cycle();
        idle();
        chk("t1_push_release", {31'b0, st_push_}, 32'h1);
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("t1_pop", {31'b0, st_pop_}, 32'h0);
        cycle();
        idle();
        chk("t1_pred_addr", pred_addr, 32'h1004);
        chk("t1_pred_v", {31'b0, pred_v}, 32'h1);
        cycle();
        chk("t1_pred_v_pulse", {31'b0, pred_v}, 32'h0);
        chk("t1_pred_hold", pred_addr, 32'h1004);

        // 2: overflow by one
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'(i * 32'h100));
            cycle();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h500);
        chk("t2_busy_no_push", {31'b0, st_push_}, 32'h1);
        cycle();
        idle();
        chk("t2_ovf", {31'b0, ovf}, 32'h1);
        chk("t2_state_ovf", {30'b0, dbg_state}, {30'b0, S_OVF});
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("t2_ret1_no_pop", {31'b0, st_pop_}, 32'h1);
        cycle();
        idle();
        chk("t2_ret1_pred_v", {31'b0, pred_v}, 32'h0);
        chk("t2_ret1_ovf", {31'b0, ovf}, 32'h0);
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("t2_ret2_pop", {31'b0, st_pop_}, 32'h0);
        cycle();
        idle();
        chk("t2_pred_addr", pred_addr, 32'h404);
        chk("t2_pred_v", {31'b0, pred_v}, 32'h1);
        drive(1'b1, 1'b1, 1'b0, '0);
        cycle();
        idle();

        // 3: saturation and flush
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'(32'h8000 + i * 16));
            cycle();
        end
        for (int i = 0; i < OVF_MAX + 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h9000);
            cycle();
            if (i == OVF_MAX - 2) chk("t3_not_sat_yet", {30'b0, dbg_state}, {30'b0, S_OVF});
            if (i == OVF_MAX - 1) begin
                chk("t3_sat", {30'b0, dbg_state}, {30'b0, S_SAT});
                chk("t3_lost_not_yet", {31'b0, lost}, 32'h0);
            end
        end
        idle();
        chk("t3_sat_hold", {30'b0, dbg_state}, {30'b0, S_SAT});
        chk("t3_lost", {31'b0, lost}, 32'h1);
        chk("t3_ovf", {31'b0, ovf}, 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h9000);
        chk("t3_st_flush", {31'b0, st_flush_}, 32'h0);
        chk("t3_flush_no_push", {31'b0, st_push_}, 32'h1);
        chk("t3_flush_no_pop", {31'b0, st_pop_}, 32'h1);
        cycle();
        idle();
        chk("t3_flush_ovf", {31'b0, ovf}, 32'h0);
        chk("t3_flush_lost", {31'b0, lost}, 32'h0);
        chk("t3_flush_state", {30'b0, dbg_state}, {30'b0, S_RUN});
        chk("t3_flush_pred_v", {31'b0, pred_v}, 32'h0);
        chk("t3_st_flush_release", {31'b0, st_flush_}, 32'h1);

        // 4: simultaneous call + return
        drive(1'b0, 1'b1, 1'b1, 32'h1000);
        cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h2000);
        chk("t4_pop", {31'b0, st_pop_}, 32'h0);
        chk("t4_push", {31'b0, st_push_}, 32'h0);
        chk("t4_wd", st_wd, 32'h2004);
        cycle();
        idle();
        chk("t4_pred_addr", pred_addr, 32'h1004);
        chk("t4_pred_v", {31'b0, pred_v}, 32'h1);
        drive(1'b1, 1'b0, 1'b1, '0);
        cycle();
        idle();
        chk("t4_pred_addr2", pred_addr, 32'h2004);
        chk("t4_pred_v2", {31'b0, pred_v}, 32'h1);

        // 5: underflow and address wrap
        drive(1'b1, 1'b0, 1'b1, '0);
        chk("t5_no_pop", {31'b0, st_pop_}, 32'h1);
        cycle();
        idle();
        chk("t5_pred_v", {31'b0, pred_v}, 32'h0);
        chk("t5_ovf", {31'b0, ovf}, 32'h0);
        chk("t5_pred_hold", pred_addr, 32'h2004);
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("t5_wd_wrap", st_wd, 32'h0);
        chk("t5_push", {31'b0, st_push_}, 32'h0);
        cycle();
        idle();

        // 6: reset mid-operation
        drive(1'b0, 1'b1, 1'b1, 32'h3000);
        chk("t6_push_before", {31'b0, st_push_}, 32'h0);
        reset_ = 1'b0;
        #1;
        chk("t6_push_reset", {31'b0, st_push_}, 32'h1);
        chk("t6_pred_addr_reset", pred_addr, 32'h0);
        cycle();
        idle();
        reset_ = 1'b1;
        #1;
        chk("t6_pred_addr", pred_addr, 32'h0);
        chk("t6_pred_v", {31'b0, pred_v}, 32'h0);
        chk("t6_ovf", {31'b0, ovf}, 32'h0);
        chk("t6_lost", {31'b0, lost}, 32'h0);
        chk("t6_strobes", {29'b0, st_push_, st_pop_, st_flush_}, 32'h7);
        cycle();
        chk("t6_strobes_after", {29'b0, st_push_, st_pop_, st_flush_}, 32'h7);
        chk("t6_pred_v_after", {31'b0, pred_v}, 32'h0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
